// File: rtl/shift_issue_unit.sv
// ---------------------------------------------------------------------------
// shift_issue_unit
//
// Two-stage issue wrapper around an external combinational barrel shifter.
// S1 holds a decoded shift request and drives the shifter. S2 captures the
// shifter result and presents it to the consumer.
//
// Handshake: a transfer happens on a rising edge where valid && ready on
// the same side. The producer may not withdraw or alter a request while
// valid is high and ready is low. in_ready never looks at in_valid.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake
//   in_funct              : shift opcode (funct field)
//   in_rs                 : variable shift amount source (low SW bits)
//   in_rt                 : data to shift
//   in_sa                 : immediate shift amount
//   in_rd                 : destination tag, carried unchanged
//   sh_din/sh_shamt       : operand and amount to the external shifter
//   sh_al/sh_lr           : 1=arithmetic/0=logical, 1=left/0=right
//   sh_dout               : shifter result, same cycle as sh_* drive
//   out_valid/out_ready   : result handshake
//   out_data/out_rd       : result and its tag
//   out_err               : request carried an unsupported funct
//   done_cnt              : saturating count of results handed off
// ---------------------------------------------------------------------------
module shift_issue_unit #(
   parameter int DW = 32,
   parameter int SW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [5:0]    in_funct,
   input  logic [DW-1:0] in_rs,
   input  logic [DW-1:0] in_rt,
   input  logic [SW-1:0] in_sa,
   input  logic [4:0]    in_rd,
   output logic [DW-1:0] sh_din,
   output logic [SW-1:0] sh_shamt,
   output logic          sh_al,
   output logic          sh_lr,
   input  logic [DW-1:0] sh_dout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [4:0]    out_rd,
   output logic          out_err,
   output logic [15:0]   done_cnt
);

   // S1: decoded request
   logic          s1_valid_q, s1_valid_d;
   logic [DW-1:0] s1_din_q,   s1_din_d;
   logic [SW-1:0] s1_amt_q,   s1_amt_d;
   logic          s1_al_q,    s1_al_d;
   logic          s1_lr_q,    s1_lr_d;
   logic [4:0]    s1_rd_q,    s1_rd_d;
   logic          s1_err_q,   s1_err_d;

   // S2: result
   logic          s2_valid_q, s2_valid_d;
   logic [DW-1:0] s2_data_q,  s2_data_d;
   logic [4:0]    s2_rd_q,    s2_rd_d;
   logic          s2_err_q,   s2_err_d;

   logic [15:0]   done_cnt_q, done_cnt_d;

   logic          s1_adv;
   logic          accept;
   logic          out_xfer;

   // Decoded fields of the incoming request
   logic          dec_lr;
   logic          dec_al;
   logic [SW-1:0] dec_amt;
   logic          dec_err;

   // S1 moves forward whenever S2 is empty or S2 drains this same edge.
   assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s1_adv;
   assign accept   = in_valid && in_ready;
   assign out_xfer = s2_valid_q && out_ready;

   // Unsupported functs become a logical right shift by zero, so the
   // result passes in_rt through untouched with the error flag set.
   always_comb begin
      dec_lr  = 1'b0;
      dec_al  = 1'b0;
      dec_amt = '0;
      dec_err = 1'b0;
      unique case (in_funct)
         6'b000000: begin dec_lr = 1'b1; dec_amt = in_sa;          end // SLL
         6'b000010: begin                dec_amt = in_sa;          end // SRL
         6'b000011: begin dec_al = 1'b1; dec_amt = in_sa;          end // SRA
         6'b000100: begin dec_lr = 1'b1; dec_amt = in_rs[SW-1:0];  end // SLLV
         6'b000110: begin                dec_amt = in_rs[SW-1:0];  end // SRLV
         6'b000111: begin dec_al = 1'b1; dec_amt = in_rs[SW-1:0];  end // SRAV
         default:   begin dec_err = 1'b1;                          end
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_din_d   = s1_din_q;
      s1_amt_d   = s1_amt_q;
      s1_al_d    = s1_al_q;
      s1_lr_d    = s1_lr_q;
      s1_rd_d    = s1_rd_q;
      s1_err_d   = s1_err_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_rd_d    = s2_rd_q;
      s2_err_d   = s2_err_q;
      done_cnt_d = done_cnt_q;

      // A new request may replace the one advancing out of S1 on the same
      // edge, which keeps throughput at one per cycle.
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_din_d   = in_rt;
         s1_amt_d   = dec_amt;
         s1_al_d    = dec_al;
         s1_lr_d    = dec_lr;
         s1_rd_d    = in_rd;
         s1_err_d   = dec_err;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      // S2 only loads when it is empty or draining, so its contents are
      // stable while the consumer stalls.
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_data_d  = sh_dout;
         s2_rd_d    = s1_rd_q;
         s2_err_d   = s1_err_q;
      end else if (out_xfer) begin
         s2_valid_d = 1'b0;
      end

      if (out_xfer && (done_cnt_q != 16'hFFFF)) begin
         done_cnt_d = done_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_din_q   <= '0;
         s1_amt_q   <= '0;
         s1_al_q    <= 1'b0;
         s1_lr_q    <= 1'b0;
         s1_rd_q    <= '0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_rd_q    <= '0;
         s2_err_q   <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_din_q   <= s1_din_d;
         s1_amt_q   <= s1_amt_d;
         s1_al_q    <= s1_al_d;
         s1_lr_q    <= s1_lr_d;
         s1_rd_q    <= s1_rd_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_rd_q    <= s2_rd_d;
         s2_err_q   <= s2_err_d;
         done_cnt_q <= done_cnt_d;
      end
   end

   assign sh_din    = s1_din_q;
   assign sh_shamt  = s1_amt_q;
   assign sh_al     = s1_al_q;
   assign sh_lr     = s1_lr_q;

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_rd    = s2_rd_q;
   assign out_err   = s2_err_q;
   assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_issue_unit
//
// Bench for shift_issue_unit. Provides the external barrel shifter, directed
// cases for the documented examples, then randomized traffic. The reference
// model views the unit as a two-entry in-order buffer: an entry becomes
// visible at the output one edge after acceptance once it is the oldest,
// and the buffer refuses new work only when full and not draining.
// ---------------------------------------------------------------------------
module tb_shift_issue_unit;

   localparam int DW = 32;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [5:0]    in_funct = '0;
   logic [DW-1:0] in_rs = '0;
   logic [DW-1:0] in_rt = '0;
   logic [SW-1:0] in_sa = '0;
   logic [4:0]    in_rd = '0;
   logic [DW-1:0] sh_din;
   logic [SW-1:0] sh_shamt;
   logic          sh_al;
   logic          sh_lr;
   logic [DW-1:0] sh_dout;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic [4:0]    out_rd;
   logic          out_err;
   logic [15:0]   done_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [DW-1:0] exp_q[$];
   logic [4:0]    rd_q[$];
   logic          err_q[$];
   int            age_q[$];
   logic [15:0]   done_exp = '0;

   shift_issue_unit #(.DW(DW), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_funct  (in_funct),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_sa     (in_sa),
      .in_rd     (in_rd),
      .sh_din    (sh_din),
      .sh_shamt  (sh_shamt),
      .sh_al     (sh_al),
      .sh_lr     (sh_lr),
      .sh_dout   (sh_dout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_rd    (out_rd),
      .out_err   (out_err),
      .done_cnt  (done_cnt)
   );

   // Clock
   always #5 clk = ~clk;

   // External combinational barrel shifter
   always_comb begin
      sh_dout = '0;
      if (sh_lr)      sh_dout = sh_din << sh_shamt;
      else if (sh_al) sh_dout = DW'($signed(sh_din) >>> sh_shamt);
      else            sh_dout = sh_din >> sh_shamt;
   end

   // Expected result of one request, straight from the opcode table
   function automatic void ref_op(input logic [5:0] f, input logic [DW-1:0] rs,
                                  input logic [DW-1:0] rt, input logic [SW-1:0] sa,
                                  output logic [DW-1:0] res, output logic err);
      int amt_v;
      amt_v = int'(rs % DW);
      err = 1'b0;
      case (f)
         6'h00:   res = rt << sa;
         6'h02:   res = rt >> sa;
         6'h03:   res = DW'($signed(rt) >>> sa);
         6'h04:   res = rt << amt_v;
         6'h06:   res = rt >> amt_v;
         6'h07:   res = DW'($signed(rt) >>> amt_v);
         default: begin res = rt; err = 1'b1; end
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      rd_q.delete();
      err_q.delete();
      age_q.delete();
      done_exp = '0;
   endtask

   // One clock cycle: inputs are already driven. Check outputs against the
   // model, then advance the model across the rising edge.
   task automatic step();
      logic          ov_exp, ir_exp, acc, xfer;
      logic [DW-1:0] r;
      logic          e;
      #1;
      ov_exp = (exp_q.size() > 0) && (age_q[0] >= 1);
      ir_exp = (exp_q.size() < 2) || out_ready;
      chk("out_valid", {31'd0, out_valid}, {31'd0, ov_exp});
      chk("in_ready", {31'd0, in_ready}, {31'd0, ir_exp});
      chk("done_cnt", {16'd0, done_cnt}, {16'd0, done_exp});
      if (ov_exp) begin
         chk("out_data", out_data, exp_q[0]);
         chk("out_rd", {27'd0, out_rd}, {27'd0, rd_q[0]});
         chk("out_err", {31'd0, out_err}, {31'd0, err_q[0]});
      end
      acc  = in_valid && ir_exp;
      xfer = ov_exp && out_ready;
      ref_op(in_funct, in_rs, in_rt, in_sa, r, e);
      @(posedge clk);
      if (xfer) begin
         void'(exp_q.pop_front());
         void'(rd_q.pop_front());
         void'(err_q.pop_front());
         void'(age_q.pop_front());
         if (done_exp != 16'hFFFF) done_exp++;
      end
      foreach (age_q[i]) age_q[i]++;
      if (acc) begin
         exp_q.push_back(r);
         rd_q.push_back(in_rd);
         err_q.push_back(e);
         age_q.push_back(0);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_rd_err", {26'd0, out_rd, out_err}, 32'd0);
      chk("rst_sh", {sh_din[25:0], sh_shamt, sh_al}, 32'd0);
      chk("rst_sh_hi", {26'd0, sh_din[31:26]}, {26'd0, 6'd0});
      chk("rst_sh_lr", {31'd0, sh_lr}, 32'd0);
   endtask

   task automatic send(input logic [5:0] f, input logic [DW-1:0] rs,
                       input logic [DW-1:0] rt, input logic [SW-1:0] sa,
                       input logic [4:0] rd);
      in_valid = 1'b1;
      in_funct = f;
      in_rs    = rs;
      in_rt    = rt;
      in_sa    = sa;
      in_rd    = rd;
   endtask

   logic [5:0] ops[6];

   initial begin
      ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      @(negedge clk);
      do_reset();

      // Stalled consumer: two accepted, third refused until release
      out_ready = 1'b0;
      send(6'h00, 0, 32'h1, 5'd1, 5'd1); step();
      send(6'h02, 0, 32'h80, 5'd2, 5'd2); step();
      send(6'h03, 0, 32'hF000_0000, 5'd4, 5'd3);
      #1 chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_hold_data", out_data, 32'h2);
      step();
      chk("stall_hold_data2", out_data, 32'h2);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1 chk("order_b", out_data, 32'h20);
      step();
      #1 chk("order_c", out_data, 32'hFF00_0000);
      step();
      #1 chk("stall_done_cnt", {16'd0, done_cnt}, 32'd3);
      step();

      // SLL latency: visible one edge after the acceptance edge
      send(6'h00, 0, 32'h1, 5'd4, 5'd7); step();
      in_valid = 1'b0;
      #1 chk("sll_not_yet", {31'd0, out_valid}, 32'd0);
      step();
      #1 chk("sll_data", out_data, 32'h10);
      chk("sll_err", {31'd0, out_err}, 32'd0);
      step();

      // SRA / SRL / SRLV / SLLV / bad funct, back to back
      send(6'h03, 0, 32'h8000_0000, 5'd31, 5'd0); step();
      send(6'h02, 0, 32'h8000_0000, 5'd31, 5'd0); step();
      #1 chk("sra_data", out_data, 32'hFFFF_FFFF);
      send(6'h06, 32'hFFFF_FF23, 32'hF0, 5'd0, 5'd9); step();
      #1 chk("srl_data", out_data, 32'h1);
      send(6'h04, 32'h20, 32'h5, 5'd0, 5'd10); step();
      #1 chk("srlv_data", out_data, 32'h1E);
      send(6'h20, 0, 32'h1234_5678, 5'd7, 5'd11); step();
      #1 chk("sllv_data", out_data, 32'h5);
      in_valid = 1'b0;
      step();
      #1 chk("bad_data", out_data, 32'h1234_5678);
      chk("bad_err", {31'd0, out_err}, 32'd1);
      step();

      // Reset with both stages full and transfers pending on that edge
      out_ready = 1'b0;
      send(6'h00, 0, 32'hA, 5'd1, 5'd1); step();
      send(6'h00, 0, 32'hB, 5'd1, 5'd2); step();
      out_ready = 1'b1;
      do_reset();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         int pick;
         pick = $urandom_range(0, 7);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_funct  = (pick < 6) ? ops[pick] : 6'($urandom);
         in_rs     = $urandom;
         in_rt     = $urandom;
         in_sa     = 5'($urandom);
         in_rd     = 5'($urandom);
         step();
      end

      // Drain
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
